// File: rtl/arb_rr_ctrl_if.sv
// arb_rr_ctrl_if: request/grant bundle between requesting agents (master) and the arbiter (slave).
interface arb_rr_ctrl_if #(parameter int N = 2);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  logic [N-1:0] request;
  logic [N-1:0] grant;
  logic         busy;
  logic [W-1:0] owner;
  modport master (output request, input grant, busy, owner);
  modport slave  (input request, output grant, busy, owner);
endinterface

// File: rtl/arb_rr_ctrl.sv
// arb_rr_ctrl: round-robin arbiter with registered one-hot grant and persistent ownership.
// Define ARB_RR_HOLD_LIMIT_EN to force rotation after MAX_HOLD owned cycles.
module arb_rr_ctrl #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  arb_rr_ctrl_if.slave bus
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, OWNED} state_e;
  if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("arb_rr_ctrl: N or MAX_HOLD out of range");
  end
  state_e       state_q, state_d;
  logic [N-1:0] grant_q, grant_d, req_m;
  logic [W-1:0] owner_q, owner_d, ptr_q, ptr_d, win;
  logic         busy_q, busy_d, found, keep, force_rot;
`ifdef ARB_RR_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;
  assign force_rot = hold_q == 8'(MAX_HOLD) && |(bus.request & ~grant_q);
  always_comb begin
    hold_d = keep ? ((hold_q == 8'(MAX_HOLD)) ? hold_q : hold_q + 8'd1) : found ? 8'd1 : hold_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign force_rot = 1'b0;
`endif
  // The owner is masked out so a forced rotation can only pick someone else.
  always_comb begin
    req_m = bus.request & ~grant_q;
    found = 1'b0;
    win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_m[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        win   = W'((int'(ptr_q) + i) % N);
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    keep    = state_q == OWNED && |(bus.request & grant_q) && !force_rot;
    state_d = (keep || found) ? OWNED : IDLE;
    ptr_d   = (!keep && found) ? ((int'(win) == N - 1) ? '0 : win + W'(1)) : ptr_q;
  end
  always_comb begin
    grant_d = (state_d == IDLE) ? '0 : keep ? grant_q : N'(1) << win;
    owner_d = (keep || !found) ? owner_q : win;
    busy_d  = state_d == OWNED;
  end
  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_arb_rr_ctrl.sv
// tb_arb_rr_ctrl: scoreboard bench for arb_rr_ctrl with N=2, MAX_HOLD=4.
module tb_arb_rr_ctrl;
  typedef struct packed {logic [1:0] g; logic o; logic b;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t q[$];
  exp_t e;
  int n_chk = 0;
  int n_pass = 0;
  arb_rr_ctrl_if #(.N(2)) bus ();
  arb_rr_ctrl #(.N(2), .MAX_HOLD(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.request = 2'b00;
    q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic cyc(input logic [1:0] r, input logic [1:0] g, input logic o, input logic b);
    @(negedge clk);
    bus.request = r;
    q.push_back(exp_t'{g: g, o: o, b: b});
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.request = 2'b11;
    #3;
    n_chk++;
    if (bus.grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", bus.grant); else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_chk++;
    if (bus.owner !== 1'b0) $display("FAIL reset_owner: got %b want 0", bus.owner); else n_pass++;
  endtask
  task automatic test_single();
    logic [1:0] r[5], g[5];
    logic o[5], b[5];
    r = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    g = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    b = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(r[i], g[i], o[i], b[i]);
      e = q.pop_front();
      n_chk++;
      if ({bus.grant, bus.owner, bus.busy} !== e)
        $display("FAIL single step %0d: got g=%b o=%b b=%b want g=%b o=%b b=%b", i, bus.grant, bus.owner, bus.busy, e.g, e.o, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_handover();
    logic [1:0] r[5], g[5];
    logic o[5], b[5];
    r = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b11};
    g = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
    o = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(r[i], g[i], o[i], b[i]);
      e = q.pop_front();
      n_chk++;
      if ({bus.grant, bus.owner, bus.busy} !== e)
        $display("FAIL handover step %0d: got g=%b o=%b b=%b want g=%b o=%b b=%b", i, bus.grant, bus.owner, bus.busy, e.g, e.o, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_wrap();
    logic [1:0] r[3], g[3];
    logic o[3], b[3];
    r = '{2'b01, 2'b00, 2'b11};
    g = '{2'b01, 2'b00, 2'b10};
    o = '{1'b0, 1'b0, 1'b1};
    b = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(r[i], g[i], o[i], b[i]);
      e = q.pop_front();
      n_chk++;
      if ({bus.grant, bus.owner, bus.busy} !== e)
        $display("FAIL wrap step %0d: got g=%b o=%b b=%b want g=%b o=%b b=%b", i, bus.grant, bus.owner, bus.busy, e.g, e.o, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_hold_all();
    logic sel;
    do_reset();
    for (int i = 0; i < 20; i++) begin
`ifdef ARB_RR_HOLD_LIMIT_EN
      sel = ((i / 4) % 2) == 1;
`else
      sel = 1'b0;
`endif
      cyc(2'b11, sel ? 2'b10 : 2'b01, sel, 1'b1);
      e = q.pop_front();
      n_chk++;
      if ({bus.grant, bus.owner, bus.busy} !== e)
        $display("FAIL hold_all cycle %0d: got g=%b o=%b b=%b want g=%b o=%b b=%b", i, bus.grant, bus.owner, bus.busy, e.g, e.o, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_hold_single();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(2'b01, 2'b01, 1'b0, 1'b1);
      e = q.pop_front();
      n_chk++;
      if ({bus.grant, bus.owner, bus.busy} !== e)
        $display("FAIL hold_single cycle %0d: got g=%b o=%b b=%b want g=%b o=%b b=%b", i, bus.grant, bus.owner, bus.busy, e.g, e.o, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    cyc(2'b10, 2'b10, 1'b1, 1'b1);
    e = q.pop_front();
    n_chk++;
    if ({bus.grant, bus.owner, bus.busy} !== e)
      $display("FAIL async_pre: got g=%b o=%b b=%b want g=%b o=%b b=%b", bus.grant, bus.owner, bus.busy, e.g, e.o, e.b);
    else n_pass++;
    #2;
    reset = 1'b0;
    bus.request = 2'b00;
    #1;
    n_chk++;
    if (bus.grant !== 2'b00) $display("FAIL async_grant: got %b want 00", bus.grant); else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL async_busy: got %b want 0", bus.busy); else n_pass++;
    n_chk++;
    if (bus.owner !== 1'b0) $display("FAIL async_owner: got %b want 0", bus.owner); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    cyc(2'b11, 2'b01, 1'b0, 1'b1);
    e = q.pop_front();
    n_chk++;
    if ({bus.grant, bus.owner, bus.busy} !== e)
      $display("FAIL async_post: got g=%b o=%b b=%b want g=%b o=%b b=%b", bus.grant, bus.owner, bus.busy, e.g, e.o, e.b);
    else n_pass++;
  endtask
  initial begin
    bus.request = 2'b00;
    test_reset();
    test_single();
    test_handover();
    test_wrap();
    test_hold_all();
    test_hold_single();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/arb_rr_ctrl.md
# arb_rr_ctrl

Round-robin arbiter controller that shares one resource between N requesters. It is the DUT side of the arbiter interface: it consumes `request` and `reset` and drives a registered one-hot `grant`. Ownership persists while the owner keeps requesting. A compile-time hold limit can force rotation so a single requester cannot starve the others. It sits between the requesting agents and the shared resource.

## Interface
- `N`, 2: number of requesters; 2 to 16.
- `MAX_HOLD`, 8: maximum consecutive owned cycles before forced rotation; 1 to 255. Used only with the hold-limit feature.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `request`  input  N  per-requester level request; bit i belongs to requester i.
- `grant`  output  N  registered grant; one-hot or all-zero.
- `busy`  output  1  registered; high whenever any grant bit is high.
- `owner`  output  $clog2(N)  registered index of the current grant holder; holds its last value when idle.

## Operation
- States:
  - IDLE: `grant`=0.
  - OWNED: exactly one `grant` bit set.
- Round-robin pointer `ptr`:
  - Search starts at `ptr`, wraps N-1→0, and picks the first set `request` bit.
  - On every new grant to index k, `ptr` ← (k+1) mod N.
- IDLE → OWNED: `request`≠0 at a clock edge; grant the RR winner.
- OWNED, owner's `request` still high:
  - Keep ownership.
  - `hold_cnt` increments, saturating at MAX_HOLD.
- OWNED, owner's `request` low:
  - If other requests are pending, switch directly to the RR winner. No idle gap.
  - Otherwise go to IDLE.
- Forced rotation (feature enabled only):
  - Condition: `hold_cnt`==MAX_HOLD, owner still requesting, and another requester pending.
  - Grant moves to the RR winner among the other requesters.
  - If no other requester is pending, the owner keeps the grant and `hold_cnt` stays saturated.
- `hold_cnt` resets to 1 on every new grant, including a re-grant after an IDLE cycle.
- A requester whose request was lost at a switch is not remembered. Requests are levels, so it must keep `request` high.
- `request` bits are never masked. A requester may hold its request across its own grant.

## Timing
- Reset values: `grant`=0, `busy`=0, `owner`=0, `ptr`=0, `hold_cnt`=0, state IDLE.
- Reset is asynchronous on assertion. Deassertion is synchronized externally; the first grant comes on the first edge after reset release at which `request`≠0.
- Grant latency: a request sampled at edge k produces `grant` at edge k. It is visible in the cycle after edge k and remains until the edge that samples a release or a rotation.
- Release latency: the owner's `request` drops before edge k, so `grant` changes at edge k.
- Handover is zero-bubble: the old bit clears and the new bit sets on the same edge. `busy` stays high.
- Simultaneous requests from IDLE: lowest index at or above `ptr` wins, with wrap-around.
- All-ones request with the feature disabled: index `ptr` wins, then holds indefinitely.
- Reset asserted mid-ownership: all outputs clear immediately. The pointer returns to 0.
- `owner` and `grant` always update on the same edge and are always consistent.

## Configuration
- `ARB_RR_HOLD_LIMIT_EN`:
  - Defined: `hold_cnt` is compiled in, and forced rotation after MAX_HOLD owned cycles applies.
  - Undefined: no `hold_cnt`, and `MAX_HOLD` is ignored. The owner keeps the grant for as long as its `request` stays high. Rotation happens only on release.

## Test plan
(N=2, MAX_HOLD=4 throughout.)
- Reset release with `request`=2'b00, then 2'b01 → `grant`=2'b01 on the next edge, `owner`=0, `busy`=1; drop `request` → `grant`=2'b00.
- From reset, `request`=2'b11 → `grant`=2'b01. Requester 0 drops after 2 cycles → `grant`=2'b10 on that edge, no idle cycle; `ptr`=0 afterwards.
- With `ARB_RR_HOLD_LIMIT_EN`, `request`=2'b11 held constant → grant alternates 2'b01 ×4 cycles, then 2'b10 ×4 cycles, and so on.
- Without the macro, `request`=2'b11 held for 20 cycles → `grant`=2'b01 for all 20 cycles.
- With the macro, `request`=2'b01 held for 10 cycles → `grant`=2'b01 throughout; no gap at the 4-cycle mark.
- `reset` asserted asynchronously mid-cycle while `grant`=2'b10 → `grant`=0, `busy`=0, `owner`=0 before the next edge. After release with `request`=2'b11 → `grant`=2'b01.
